// File: rtl/pdm_cic_rx.sv
// PDM microphone receiver: mic_clk divider, 1-2 channel capture, 4th-order CIC decimator.
// Define MIC_TEST_PAT_EN to replace the CIC output with a ramp test pattern.
module pdm_cic_rx #(
    parameter int NUM_CH     = 2,
    parameter int CLK_DIV    = 20,
    parameter int LOG2_DECIM = 6,
    parameter int PCM_DSIZE  = 16
) (
    input  logic                          clk_board,
    input  logic                          rst,
    input  logic                          en_mic,
    output logic                          mic_clk,
    input  logic                          mic_data,
    output logic                          pcm_valid,
    input  logic                          pcm_ready,
    output logic [NUM_CH*PCM_DSIZE-1:0]   pcm_data,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = $clog2(CLK_DIV);
    localparam int W    = 4 * LOG2_DECIM + 2;
    localparam int SH   = 4 * LOG2_DECIM - (PCM_DSIZE - 1);
    localparam int P    = PCM_DSIZE;

    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic                    act;
    logic [LOG2_DECIM-1:0]   fcnt;
    logic [2:0]              warm;
    logic                    frm_done;
    logic [NUM_CH-1:0]       stb;
    logic                    stb_last;
    logic                    new_frame;
    logic                    blocked;
    logic [NUM_CH*P-1:0]     frame;

    always_comb begin
        cnt_nxt = '0;
        if (act) begin
            cnt_nxt = (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
        end
    end

    assign stb[0] = act && (cnt == CW'(HALF - 1));

    if (NUM_CH == 2) begin : g_stb1
        assign stb[1] = act && (cnt == CW'(CLK_DIV - 1));
    end

    assign stb_last  = stb[NUM_CH-1];
    assign new_frame = frm_done && en_mic && (warm == 3'd4);
    assign blocked   = pcm_valid && !pcm_ready;

    // Divider, frame counter and warm-up all restart whenever the block is disabled.
    always_ff @(posedge clk_board) begin
        if (rst || !en_mic) begin
            cnt      <= '0;
            act      <= 1'b0;
            mic_clk  <= 1'b0;
            fcnt     <= '0;
            warm     <= '0;
            frm_done <= 1'b0;
        end else begin
            act      <= 1'b1;
            cnt      <= cnt_nxt;
            mic_clk  <= (cnt_nxt < CW'(HALF));
            frm_done <= stb_last && (fcnt == '1);
            if (stb_last) begin
                fcnt <= fcnt + 1'b1;
            end
            if (frm_done && (warm != 3'd4)) begin
                warm <= warm + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_board) begin
        if (rst) begin
            pcm_valid <= 1'b0;
            pcm_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (new_frame && blocked) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (new_frame && !blocked) begin
                pcm_valid <= 1'b1;
                pcm_data  <= frame;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end
        end
    end

`ifdef MIC_TEST_PAT_EN
    logic [P-1:0] ramp;

    always_ff @(posedge clk_board) begin
        if (rst) begin
            ramp <= '0;
        end else if (new_frame) begin
            ramp <= ramp + 1'b1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_pat
        assign frame[ch*P +: P] = (ch == 0) ? ramp : ~ramp;
    end
`else
    localparam logic signed [W-1:0] SMAX = W'((1 << (P - 1)) - 1);
    localparam logic signed [W-1:0] SMIN = ~SMAX;

    logic [W-1:0] xw;

    assign xw = mic_data ? W'(1) : {W{1'b1}};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cic
        logic [W-1:0]        i0, i1, i2, i3;
        logic [W-1:0]        i0n, i1n, i2n, i3n;
        logic [W-1:0]        d0, d1, d2, d3;
        logic [W-1:0]        c0, c1, c2, c3;
        logic signed [W-1:0] sh;
        logic [P-1:0]        samp;

        assign i0n = i0 + xw;
        assign i1n = i1 + i0n;
        assign i2n = i2 + i1n;
        assign i3n = i3 + i2n;

        assign c0 = i3 - d0;
        assign c1 = c0 - d1;
        assign c2 = c1 - d2;
        assign c3 = c2 - d3;

        assign sh = $signed(c3) >>> SH;

        always_comb begin
            if (sh > SMAX) begin
                samp = {1'b0, {(P-1){1'b1}}};
            end else if (sh < SMIN) begin
                samp = {1'b1, {(P-1){1'b0}}};
            end else begin
                samp = sh[P-1:0];
            end
        end

        assign frame[ch*P +: P] = samp;

        always_ff @(posedge clk_board) begin
            if (rst || !en_mic) begin
                i0 <= '0;
                i1 <= '0;
                i2 <= '0;
                i3 <= '0;
                d0 <= '0;
                d1 <= '0;
                d2 <= '0;
                d3 <= '0;
            end else begin
                if (stb[ch]) begin
                    i0 <= i0n;
                    i1 <= i1n;
                    i2 <= i2n;
                    i3 <= i3n;
                end
                if (frm_done) begin
                    d0 <= i3;
                    d1 <= c0;
                    d2 <= c1;
                    d3 <= c2;
                end
            end
        end
    end
`endif

endmodule
